// File: rtl/token_manager.sv
// token_manager
//   Park-slot allocator for the parking lot. Each of the 2**PARK_W slots has
//   an occupied bit and a stored token. An entry takes the lowest free slot
//   and issues token = park ^ pattern, where pattern is an LFSR that steps
//   once per issued token. An exit frees a slot only when the presented token
//   matches the stored one.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   entry_req/ready       entry handshake (exit wins a same-cycle tie)
//   entry_ack/full        one-cycle result pulses for an accepted entry
//   entry_park/token      allocated slot and issued token (held between acks)
//   exit_req/ready        exit handshake
//   exit_park/token       slot and token presented, sampled on acceptance
//   exit_ok/err           one-cycle result pulses for an accepted exit
//   busy                  slot scan in progress
//   count                 occupied slot count
module token_manager #(
  parameter int                  PARK_W       = 3,
  parameter logic [PARK_W-1:0]   PATTERN_SEED = 3'b101,
  parameter logic [PARK_W-1:0]   LFSR_TAPS    = 3'b110
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entry_req,
  output logic              entry_ready,
  output logic              entry_ack,
  output logic              entry_full,
  output logic [PARK_W-1:0] entry_park,
  output logic [PARK_W-1:0] entry_token,
  input  logic              exit_req,
  output logic              exit_ready,
  input  logic [PARK_W-1:0] exit_park,
  input  logic [PARK_W-1:0] exit_token,
  output logic              exit_ok,
  output logic              exit_err,
  output logic              busy,
  output logic [PARK_W:0]   count
);

  localparam int             N_PARKS  = 1 << PARK_W;
  localparam logic [PARK_W:0] FULL_CNT = (PARK_W+1)'(N_PARKS);
  localparam logic [PARK_W:0] ONE_CNT  = (PARK_W+1)'(1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                         state, state_nxt;
  logic [N_PARKS-1:0]             occ;
  logic [N_PARKS-1:0][PARK_W-1:0] tbl;
  logic [PARK_W-1:0]              pattern, pattern_nxt;
  logic [PARK_W-1:0]              idx;

  logic entry_go, exit_go, lot_full, slot_free, tok_match;

  // Handshake, next state and LFSR step.
  always_comb begin
    exit_ready  = (state == IDLE);
    entry_ready = (state == IDLE) && !exit_req;
    exit_go     = exit_req && exit_ready;
    entry_go    = entry_req && entry_ready;
    lot_full    = (count == FULL_CNT);
    slot_free   = !occ[idx];
    tok_match   = occ[exit_park] && (tbl[exit_park] == exit_token);
    busy        = (state == SCAN);
    pattern_nxt = {pattern[PARK_W-2:0], ^(pattern & LFSR_TAPS)};
    state_nxt   = state;
    case (state)
      IDLE: if (entry_go && !lot_full) state_nxt = SCAN;
      SCAN: if (slot_free)             state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_ack   <= 1'b0;
      entry_full  <= 1'b0;
      exit_ok     <= 1'b0;
      exit_err    <= 1'b0;
      entry_park  <= '0;
      entry_token <= '0;
      count       <= '0;
      occ         <= '0;
      tbl         <= '0;
      pattern     <= PATTERN_SEED;
      idx         <= '0;
    end else begin
      entry_ack  <= 1'b0;
      entry_full <= 1'b0;
      exit_ok    <= 1'b0;
      exit_err   <= 1'b0;

      // Exit is only accepted in IDLE, so it never collides with a scan hit.
      if (exit_go) begin
        if (tok_match) begin
          exit_ok        <= 1'b1;
          occ[exit_park] <= 1'b0;
          count          <= count - ONE_CNT;
        end else begin
          exit_err <= 1'b1;
        end
      end

      if (entry_go) begin
        if (lot_full) entry_full <= 1'b1;
        else          idx        <= '0;
      end

      // One slot per cycle; a free slot is guaranteed once the full check
      // passed, so idx never needs to wrap.
      if (state == SCAN) begin
        if (slot_free) begin
          entry_ack   <= 1'b1;
          entry_park  <= idx;
          entry_token <= idx ^ pattern;
          occ[idx]    <= 1'b1;
          tbl[idx]    <= idx ^ pattern;
          count       <= count + ONE_CNT;
          pattern     <= pattern_nxt;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_token_manager.sv
module tb_token_manager;

  localparam int W = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         entry_req = 1'b0;
  logic         entry_ready, entry_ack, entry_full;
  logic [W-1:0] entry_park, entry_token;
  logic         exit_req = 1'b0;
  logic         exit_ready;
  logic [W-1:0] exit_park = '0, exit_token = '0;
  logic         exit_ok, exit_err, busy;
  logic [W:0]   count;

  token_manager dut (
    .clk(clk), .rst(rst),
    .entry_req(entry_req), .entry_ready(entry_ready), .entry_ack(entry_ack),
    .entry_full(entry_full), .entry_park(entry_park), .entry_token(entry_token),
    .exit_req(exit_req), .exit_ready(exit_ready), .exit_park(exit_park),
    .exit_token(exit_token), .exit_ok(exit_ok), .exit_err(exit_err),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           full;
    logic [W-1:0] park;
    logic [W-1:0] token;
  } ent_exp_t;

  ent_exp_t     ent_q[$];
  bit           exit_q[$];

  // Reference model of the lot.
  logic [N-1:0] m_occ;
  logic [W-1:0] m_tbl[N];
  logic [W-1:0] m_pat;
  int           m_cnt;

  int vectors = 0;
  int errs    = 0;

  logic [W-1:0] spec_tok[N] = '{3'b101, 3'b010, 3'b101, 3'b101,
                                3'b000, 3'b100, 3'b100, 3'b010};

  function automatic logic [W-1:0] lfsr(input logic [W-1:0] p);
    return {p[W-2:0], ^(p & 3'b110)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_occ = '0;
    for (int i = 0; i < N; i++) m_tbl[i] = '0;
    m_pat = 3'b101;
    m_cnt = 0;
    ent_q.delete();
    exit_q.delete();
  endtask

  task automatic model_entry();
    ent_exp_t e;
    int       i;
    e.full = (m_cnt == N);
    e.park = '0;
    e.token = '0;
    if (!e.full) begin
      i = 0;
      while (m_occ[i]) i++;
      e.park   = W'(i);
      e.token  = W'(i) ^ m_pat;
      m_occ[i] = 1'b1;
      m_tbl[i] = e.token;
      m_cnt++;
      m_pat = lfsr(m_pat);
    end
    ent_q.push_back(e);
  endtask

  task automatic model_exit(input logic [W-1:0] p, input logic [W-1:0] t);
    bit ok;
    ok = m_occ[p] && (m_tbl[p] == t);
    if (ok) begin
      m_occ[p] = 1'b0;
      m_cnt--;
    end
    exit_q.push_back(ok);
  endtask

  // Called at the negedge of cycle 1 of an accepted entry.
  task automatic wait_entry();
    ent_exp_t e;
    int       busy_cnt = 0;
    int       c;
    bit       got = 0;
    e = ent_q.pop_front();
    for (c = 0; c < N + 3; c++) begin
      if (c > 0) @(negedge clk);
      if (entry_ack || entry_full) begin
        got = 1;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (!got) begin
      chk("entry_timeout", 0, 1);
      return;
    end
    chk("entry_full", entry_full, e.full);
    chk("entry_ack", entry_ack, !e.full);
    if (e.full) begin
      chk("full_latency", c, 0);
      chk("full_busy", busy_cnt, 0);
    end else begin
      chk("entry_park", entry_park, e.park);
      chk("entry_token", entry_token, e.token);
      chk("ack_latency", c, e.park + 1);
      chk("scan_busy", busy_cnt, e.park + 1);
    end
    chk("entry_count", count, m_cnt);
  endtask

  task automatic wait_ready(input bit is_entry);
    int n = 0;
    #1;
    while ((is_entry ? entry_ready : exit_ready) !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_entry();
    entry_req = 1'b1;
    wait_ready(1);
    model_entry();
    @(posedge clk);
    @(negedge clk);
    entry_req = 1'b0;
    wait_entry();
  endtask

  task automatic do_exit(input logic [W-1:0] p, input logic [W-1:0] t);
    bit ok;
    exit_park  = p;
    exit_token = t;
    exit_req   = 1'b1;
    wait_ready(0);
    model_exit(p, t);
    @(posedge clk);
    @(negedge clk);
    exit_req = 1'b0;
    ok = exit_q.pop_front();
    chk("exit_ok", exit_ok, ok);
    chk("exit_err", exit_err, !ok);
    chk("exit_count", count, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();

    // Reset state.
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {entry_ack, entry_full, exit_ok, exit_err}, 4'b0000);
    chk("rst_entry_ready", entry_ready, 1);
    chk("rst_exit_ready", exit_ready, 1);

    // First and second entries; park/token hold after the ack pulse.
    do_entry();
    chk("t1_token_const", entry_token, 3'b101);
    do_entry();
    chk("t2_token_const", entry_token, 3'b010);
    @(negedge clk);
    chk("hold_ack_low", entry_ack, 0);
    chk("hold_park", entry_park, 3'd1);
    chk("hold_token", entry_token, 3'b010);

    // Exit: match, wrong token, empty slot.
    do_exit(3'd0, 3'b101);
    do_exit(3'd1, 3'b111);
    do_exit(3'd0, 3'b101);

    // Fill from reset, then one over the limit.
    do_reset();
    for (int i = 0; i < N; i++) begin
      do_entry();
      chk("fill_token_const", entry_token, spec_tok[i]);
    end
    do_entry();
    chk("full_count", count, N);

    // Simultaneous exit and entry on a full lot: exit wins, freed slot reused.
    exit_park  = 3'd3;
    exit_token = m_tbl[3];
    exit_req   = 1'b1;
    entry_req  = 1'b1;
    model_exit(3'd3, m_tbl[3]);
    #1;
    chk("tie_entry_ready", entry_ready, 0);
    chk("tie_exit_ready", exit_ready, 1);
    @(posedge clk);
    @(negedge clk);
    exit_req = 1'b0;
    chk("tie_exit_ok", exit_ok, exit_q.pop_front());
    chk("tie_count", count, N - 1);
    #1;
    chk("tie_entry_ready_next", entry_ready, 1);
    model_entry();
    @(posedge clk);
    @(negedge clk);
    entry_req = 1'b0;
    wait_entry();

    // Reset in the middle of a scan.
    do_reset();
    for (int i = 0; i < 6; i++) do_entry();
    entry_req = 1'b1;
    wait_ready(1);
    @(posedge clk);
    @(negedge clk);
    entry_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("abort_no_ack", entry_ack, 0);
      chk("abort_busy", busy, 1);
      if (c < 3) @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_count", count, 0);
    chk("abort_busy_low", busy, 0);
    chk("abort_ack_low", entry_ack, 0);
    do_entry();
    chk("abort_next_park", entry_park, 3'd0);
    chk("abort_next_token", entry_token, 3'b101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
